// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b one bit per clock, LSB first,
// framed by a start/busy/done handshake with registered results.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             zero_q;

    logic             bit_d;
    logic             br_d;
    logic [WIDTH:0]   res_ext_s;
    logic [WIDTH-1:0] res_d;

    // Two cascaded half subtractors on the current LSBs and the stored borrow.
    always_comb begin
        bit_d     = a_q[0] ^ b_q[0] ^ br_q;
        br_d      = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        // Widened concat keeps the shift-in legal for WIDTH == 1.
        res_ext_s = {bit_d, res_q};
        res_d     = res_ext_s[WIDTH:1];
    end

    // Control FSM with datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            res_q    <= {WIDTH{1'b0}};
            br_q     <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_SHIFT;
                        a_q     <= a;
                        b_q     <= b;
                        res_q   <= {WIDTH{1'b0}};
                        br_q    <= 1'b0;
                        cnt_q   <= {CW{1'b0}};
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        diff_q   <= res_d;
                        borrow_q <= br_d;
                        zero_q   <= (res_d == {WIDTH{1'b0}});
                    end else begin
                        state_q  <= ST_SHIFT;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances,
// vector table plus handshake, back-to-back and mid-operation reset sequences.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'd0;
    logic [7:0] b8 = 8'd0;
    logic       busy8, done8, borrow8, zero8;
    logic [7:0] diff8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = 1'b0;
    logic [0:0] b1 = 1'b0;
    logic       busy1, done1, borrow1, zero1;
    logic [0:0] diff1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .zero(zero8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .zero(zero1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
        logic       z;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start a WIDTH=8 op, return cycles from accept edge to done and busy count.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int busy_cnt);
        start8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!done8 && lat < 50) begin
            if (busy8) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op1(input logic a, input logic b, output int lat);
        start1 = 1'b1; a1 = a; b1 = b;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat, bc, gap, seen;
        vecs[0] = '{a: 8'd5,    b: 8'd3,    d: 8'd2,    br: 1'b0, z: 1'b0};
        vecs[1] = '{a: 8'd3,    b: 8'd5,    d: 8'hFE,   br: 1'b1, z: 1'b0};
        vecs[2] = '{a: 8'd0,    b: 8'hFF,   d: 8'd1,    br: 1'b1, z: 1'b0};
        vecs[3] = '{a: 8'hA5,   b: 8'hA5,   d: 8'd0,    br: 1'b0, z: 1'b1};
        vecs[4] = '{a: 8'hFF,   b: 8'd0,    d: 8'hFF,   br: 1'b0, z: 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_diff", {24'd0, diff8}, 32'd0);
        chk("rst_borrow", {31'd0, borrow8}, 32'd0);
        chk("rst_zero", {31'd0, zero8}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Vector table
        for (int i = 0; i < 5; i++) begin
            op8(vecs[i].a, vecs[i].b, lat, bc);
            chk($sformatf("v%0d_latency", i), lat, 32'd8);
            chk($sformatf("v%0d_busy_cycles", i), bc, 32'd8);
            chk($sformatf("v%0d_diff", i), {24'd0, diff8}, {24'd0, vecs[i].d});
            chk($sformatf("v%0d_borrow", i), {31'd0, borrow8}, {31'd0, vecs[i].br});
            chk($sformatf("v%0d_zero", i), {31'd0, zero8}, {31'd0, vecs[i].z});
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done8}, 32'd0);
            chk($sformatf("v%0d_hold", i), {24'd0, diff8}, {24'd0, vecs[i].d});
        end

        // start during SHIFT is ignored
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h88;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("ign_diff_stable", {24'd0, diff8}, {24'd0, 8'hFF});
        lat = 0;
        while (!done8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ign_latency_rest", lat, 32'd4);
        chk("ign_diff", {24'd0, diff8}, 32'h0F);
        chk("ign_borrow", {31'd0, borrow8}, 32'd0);

        // Back-to-back: start held through DONE
        start8 = 1'b1; a8 = 8'd20; b8 = 8'd7;
        @(posedge clk); #1;
        a8 = 8'd7; b8 = 8'd20;
        lat = 0;
        while (!done8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_lat1", lat, 32'd8);
        chk("b2b_diff1", {24'd0, diff8}, 32'd13);
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("b2b_no_idle", {31'd0, busy8}, 32'd1);
        gap = 1;
        while (!done8 && gap < 50) begin
            @(posedge clk); #1;
            gap++;
        end
        chk("b2b_gap", gap, 32'd9);
        chk("b2b_diff2", {24'd0, diff8}, 32'hF3);
        chk("b2b_borrow2", {31'd0, borrow8}, 32'd1);

        // Reset mid-operation
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'd50; b8 = 8'd1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", {31'd0, busy8}, 32'd0);
        chk("mrst_diff", {24'd0, diff8}, 32'd0);
        chk("mrst_borrow", {31'd0, borrow8}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen++;
        end
        chk("mrst_no_done", seen, 32'd0);
        op8(8'd9, 8'd4, lat, bc);
        chk("mrst_after_lat", lat, 32'd8);
        chk("mrst_after_diff", {24'd0, diff8}, 32'd5);

        // WIDTH=1 instance, all input pairs
        for (int i = 0; i < 4; i++) begin
            logic ea, eb, ed, ebr;
            ea = i[1]; eb = i[0];
            ed = ea ^ eb;
            ebr = ~ea & eb;
            op1(ea, eb, lat);
            chk($sformatf("w1_%0d_lat", i), lat, 32'd1);
            chk($sformatf("w1_%0d_diff", i), {31'd0, diff1}, {31'd0, ed});
            chk($sformatf("w1_%0d_borrow", i), {31'd0, borrow1}, {31'd0, ebr});
            chk($sformatf("w1_%0d_zero", i), {31'd0, zero1}, {31'd0, ~ed});
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor: computes `a - b` one bit per clock, LSB first, using a half-subtractor pair plus a registered borrow. It is the inverse-operation companion to the half adder in the arithmetic library and is used where area matters more than latency, such as ALU slow paths and counters compared against limits. A start/busy/done handshake frames each operation.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width; legal range ≥ 1.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset; asynchronous assertion, active-low.
- `start`  in  1  request; sampled on rising edge; accepted only in IDLE or DONE.
- `a`  in  WIDTH  minuend; captured on the accepting edge.
- `b`  in  WIDTH  subtrahend; captured on the accepting edge.
- `busy`  out  1  high while bits are being processed (SHIFT state).
- `done`  out  1  single-cycle pulse; result valid from this cycle.
- `diff`  out  WIDTH  `(a - b) mod 2^WIDTH`.
- `borrow`  out  1  final borrow; 1 iff `a < b` (unsigned).
- `zero`  out  1  1 iff `diff == 0`.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `busy`=0, `done`=0.
  - `start`=1 loads `a` and `b` into internal shift registers.
  - Clears the borrow flop and the bit counter; next state is SHIFT.
- SHIFT: one bit per cycle from the LSBs `a0`, `b0` and borrow `br`.
  - Difference bit `d = a0 ^ b0 ^ br`.
  - Next borrow `br' = (~a0 & b0) | (~(a0 ^ b0) & br)`, i.e. two cascaded half subtractors with their borrows ORed.
  - `d` shifts into the MSB of the internal result register; the operand registers shift right.
  - Counter increments. After the WIDTH-th bit, next state is DONE.
  - On that same edge: `diff` ← internal result, `borrow` ← final `br'`, `zero` ← (result == 0).
- DONE: `done`=1 for exactly this one cycle.
  - Next state is SHIFT if `start`=1 (new operands captured, back-to-back), otherwise IDLE.
- `start` during SHIFT is ignored; operands are not re-sampled.
- `diff`, `borrow` and `zero` are registered. They change only on the SHIFT→DONE edge and hold until the next completion, so they are stable while `busy`=1.
- Counter width is `$clog2(WIDTH+1)`. The counter never wraps inside an operation.

## Timing
- Reset (async, `rst_n`=0): state IDLE. `busy`, `done`, `diff`, `borrow`, `zero`, internal registers and counter are all 0.
- `zero` reads 0 after reset even though `diff`=0; it is only meaningful after `done`.
- Reset mid-operation aborts immediately: no `done`, outputs forced to 0. The first edge after `rst_n` rises is treated as IDLE.
- Latency: `start` accepted at edge E0.
  - `busy`=1 from after E0 through edge E0+WIDTH.
  - State is DONE after edge E0+WIDTH, so `done`=1 during the cycle between edges E0+WIDTH and E0+WIDTH+1.
- Throughput: one result per WIDTH+1 cycles when `start` is held or re-asserted in DONE.
- WIDTH=1: SHIFT lasts one cycle, and the block reduces to a registered half subtractor plus borrow-in 0.

## Test plan
- WIDTH=8, start with a=5, b=3 -> `done` pulse exactly 8 cycles after the accept edge; diff=2, borrow=0, zero=0; `busy` high for 8 cycles.
- a=3, b=5 -> diff=8'hFE, borrow=1, zero=0. Then a=0, b=8'hFF -> diff=1, borrow=1.
- a=8'hA5, b=8'hA5 -> diff=0, borrow=0, zero=1. Then a=8'hFF, b=0 -> diff=8'hFF, borrow=0.
- Handshake: pulse `start` with new operands 3 cycles into SHIFT -> ignored; result equals the first operands. `start` held high in DONE -> second operation begins with no IDLE cycle; `done` pulses are WIDTH+1 cycles apart.
- Reset mid-op: deassert `rst_n` 4 cycles into SHIFT -> outputs 0 immediately, no `done`. After release, a=9, b=4 -> diff=5.
- WIDTH=1 instance, all four (a,b) pairs -> (diff,borrow) = (0,0), (1,1), (1,0), (0,0) for (0,0), (0,1), (1,0), (1,1); `done` one cycle after accept.
